// File: rtl/ecc_secded_codec_if.sv
// ECC SECDED codec bus interface.
// APB slave port plus the result bus.
interface ecc_secded_codec_if #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32
);
  logic [AMBA_ADDR_WIDTH-1:0] paddr;
  logic [AMBA_WORD-1:0]       pwdata;
  logic                       penable;
  logic                       psel;
  logic                       pwrite;
  logic [AMBA_WORD-1:0]       prdata;
  logic [DATA_WIDTH-1:0]      data_out;
  logic                       operation_done;
  logic [1:0]                 num_of_errors;

  modport master (
    output paddr, pwdata, penable, psel, pwrite,
    input  prdata, data_out, operation_done, num_of_errors
  );

  modport slave (
    input  paddr, pwdata, penable, psel, pwrite,
    output prdata, data_out, operation_done, num_of_errors
  );
endinterface

// File: rtl/ecc_secded_codec.sv
// APB-programmable SECDED codec, 8/16/32-bit codewords.
// Sequenced encode / decode / channel with error counters.
module ecc_secded_codec #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32
) (
  input logic clk,
  input logic rst,
  ecc_secded_codec_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ENC, S_SYN, S_FIX, S_DONE
  } state_t;

  localparam logic [1:0] OP_ENC = 2'd0;
  localparam logic [1:0] OP_DEC = 2'd1;

  // Hamming position of data bit i: i-th non-power-of-two.
  localparam logic [4:0] POS [26] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11,
    5'd12, 5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19,
    5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26,
    5'd27, 5'd28, 5'd29, 5'd30, 5'd31
  };

  function automatic logic [31:0] kmask(input logic [1:0] wc);
    unique case (wc)
      2'd0:    return 32'h0000_000F;
      2'd1:    return 32'h0000_07FF;
      default: return 32'h03FF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] nmask(input logic [1:0] wc);
    unique case (wc)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [4:0] pmask(input logic [1:0] wc);
    unique case (wc)
      2'd0:    return 5'h07;
      2'd1:    return 5'h0F;
      default: return 5'h1F;
    endcase
  endfunction

  function automatic logic [4:0] kbits(input logic [1:0] wc);
    unique case (wc)
      2'd0:    return 5'd4;
      2'd1:    return 5'd11;
      default: return 5'd26;
    endcase
  endfunction

  function automatic logic [4:0] topbit(input logic [1:0] wc);
    unique case (wc)
      2'd0:    return 5'd7;
      2'd1:    return 5'd15;
      default: return 5'd31;
    endcase
  endfunction

  // Parity vector is the XOR of the positions of all set data bits.
  function automatic logic [4:0] ham(input logic [25:0] d);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < 26; i++)
      if (d[i]) p ^= POS[i];
    return p;
  endfunction

  function automatic logic [31:0] enc(
    input logic [1:0]  wc,
    input logic [31:0] din
  );
    logic [31:0] d;
    logic [31:0] cw;
    d  = din & kmask(wc);
    cw = d | (32'(ham(26'(d))) << kbits(wc));
    cw[topbit(wc)] = ^cw;
    return cw;
  endfunction

  // Returns {overall parity, syndrome}.
  function automatic logic [5:0] synd(
    input logic [1:0]  wc,
    input logic [31:0] cw
  );
    logic [31:0] r;
    logic [31:0] d;
    logic [4:0]  rp;
    r  = cw & nmask(wc);
    d  = r & kmask(wc);
    rp = 5'(r >> kbits(wc)) & pmask(wc);
    return {^r, ham(26'(d)) ^ rp};
  endfunction

  state_t               state;
  logic [1:0]           op_q;
  logic [1:0]           wc_q;
  logic [31:0]          din_s;
  logic [31:0]          noise_s;
  logic [31:0]          cw_q;
  logic [4:0]           syn_q;
  logic                 ovr_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [1:0]           nerr_q;
  logic                 done_q;
  logic [AMBA_WORD-1:0] sgl_q;
  logic [AMBA_WORD-1:0] dbl_q;
  logic [AMBA_WORD-1:0] prdata_q;
  logic [AMBA_WORD-1:0] data_q;
  logic [AMBA_WORD-1:0] noise_q;
  logic [1:0]           width_q;
  logic [1:0]           ctrl_q;

  logic        busy;
  logic [4:0]  addr;
  logic        wr;
  logic        rd;
  logic        sel_ctrl, sel_data, sel_width, sel_noise;
  logic        sel_sgl, sel_dbl, sel_stat;
  logic        start;
  logic        clr_cnt;
  logic [31:0] enc_cw;
  logic [5:0]  syn_c;
  logic [31:0] fix_data;
  logic [1:0]  fix_err;
  logic        unused_addr;

  assign busy      = (state != S_IDLE);
  assign addr      = bus.paddr[4:0];
  assign wr        = bus.psel & bus.penable & bus.pwrite & ~busy;
  assign rd        = bus.psel & ~bus.penable & ~bus.pwrite;
  assign sel_ctrl  = (addr == 5'h00);
  assign sel_data  = (addr == 5'h04);
  assign sel_width = (addr == 5'h08);
  assign sel_noise = (addr == 5'h0C);
  assign sel_sgl   = (addr == 5'h10);
  assign sel_dbl   = (addr == 5'h14);
  assign sel_stat  = (addr == 5'h18);
  assign start     = wr & sel_ctrl & (bus.pwdata[1:0] != 2'd3);
  assign clr_cnt   = wr & (sel_sgl | sel_dbl);
  assign enc_cw    = enc(wc_q, din_s);
  assign syn_c     = synd(wc_q, cw_q);
  assign unused_addr = ^bus.paddr[AMBA_ADDR_WIDTH-1:5];

  // Correct the data field from the registered syndrome.
  always_comb begin
    fix_data = cw_q & kmask(wc_q);
    fix_err  = 2'd0;
    if (ovr_q) begin
      fix_err = 2'd1;
      for (int i = 0; i < 26; i++)
        if (POS[i] == syn_q) fix_data[i] = ~fix_data[i];
    end else if (syn_q != 5'd0) begin
      fix_err = 2'd2;
    end
  end

  // Configuration registers, written only while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      width_q <= '0;
      noise_q <= '0;
    end else begin
      if (wr & sel_ctrl)  ctrl_q  <= bus.pwdata[1:0];
      if (wr & sel_data)  data_q  <= bus.pwdata;
      if (wr & sel_width) width_q <= bus.pwdata[1:0];
      if (wr & sel_noise) noise_q <= bus.pwdata;
    end
  end

  // Read data captured in the setup phase, held through access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prdata_q <= '0;
    end else if (rd) begin
      unique case (1'b1)
        sel_ctrl:  prdata_q <= AMBA_WORD'(ctrl_q);
        sel_data:  prdata_q <= data_q;
        sel_width: prdata_q <= AMBA_WORD'(width_q);
        sel_noise: prdata_q <= noise_q;
        sel_sgl:   prdata_q <= sgl_q;
        sel_dbl:   prdata_q <= dbl_q;
        sel_stat:  prdata_q <= AMBA_WORD'(busy);
        default:   prdata_q <= '0;
      endcase
    end
  end

  // Operation sequencer, result bus and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      wc_q    <= '0;
      din_s   <= '0;
      noise_s <= '0;
      cw_q    <= '0;
      syn_q   <= '0;
      ovr_q   <= 1'b0;
      dout_q  <= '0;
      nerr_q  <= '0;
      done_q  <= 1'b0;
      sgl_q   <= '0;
      dbl_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= bus.pwdata[1:0];
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          wc_q    <= width_q;
          din_s   <= data_q[31:0];
          noise_s <= noise_q[31:0];
          cw_q    <= data_q[31:0] & nmask(width_q);
          state   <= (op_q == OP_DEC) ? S_SYN : S_ENC;
        end
        S_ENC: begin
          if (op_q == OP_ENC) begin
            dout_q <= enc_cw;
            nerr_q <= 2'd0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            cw_q  <= (enc_cw ^ noise_s) & nmask(wc_q);
            state <= S_SYN;
          end
        end
        S_SYN: begin
          ovr_q <= syn_c[5];
          syn_q <= syn_c[4:0];
          state <= S_FIX;
        end
        S_FIX: begin
          dout_q <= fix_data;
          nerr_q <= fix_err;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (op_q != OP_ENC) begin
            if (nerr_q == 2'd1 && !(&sgl_q))
              sgl_q <= sgl_q + AMBA_WORD'(1);
            if (nerr_q == 2'd2 && !(&dbl_q))
              dbl_q <= dbl_q + AMBA_WORD'(1);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (clr_cnt) begin
        sgl_q <= '0;
        dbl_q <= '0;
      end
    end
  end

  assign bus.prdata         = prdata_q;
  assign bus.data_out       = dout_q;
  assign bus.operation_done = done_q;
  assign bus.num_of_errors  = nerr_q;

endmodule

// File: doc/ecc_secded_codec.md
Name: ecc_secded_codec

Overview:
APB-programmable extended-Hamming (SECDED) codec with a run-time selectable codeword width of 8, 16 or 32 bits. It supports three operations: encode, decode, and full channel (encode, XOR a noise pattern, decode). Compared with the fixed encoder/decoder it adds a sequenced multi-cycle datapath, a busy lockout, and saturating error-statistics counters. It sits behind the APB slave port of the ECC subsystem and drives the data_out, operation_done and num_of_errors result bus.

Parameters:
AMBA_ADDR_WIDTH, 20, APB address width; only paddr[4:0] is decoded.
AMBA_WORD, 32, APB data width; must be at least DATA_WIDTH.
DATA_WIDTH, 32, maximum codeword width; must be 32.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-low reset.
paddr  in  AMBA_ADDR_WIDTH  APB address.
pwdata  in  AMBA_WORD  APB write data.
penable  in  1  APB access phase.
psel  in  1  APB select.
pwrite  in  1  APB write=1, read=0.
prdata  out  AMBA_WORD  APB read data.
data_out  out  DATA_WIDTH  result word, zero-extended.
operation_done  out  1  one-cycle result strobe.
num_of_errors  out  2  0 = clean, 1 = corrected single error, 2 = double error detected.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst). It is asynchronous at any time, including mid-operation.
  - All registers, counters and outputs go to 0. The FSM goes to IDLE.
  - An operation in flight is abandoned and no operation_done is produced.
- Register map (word offsets). Writes occur on psel & penable & pwrite.
  - 0x00 CTRL, bits [1:0]: 0 encode, 1 decode, 2 full channel, 3 ignored (no operation). A write starts the operation.
  - 0x04 DATA_IN.
  - 0x08 CODEWORD_WIDTH, bits [1:0]: 0 = 8, 1 = 16, 2 or 3 = 32.
  - 0x0C NOISE.
  - 0x10 SGL_CNT (read-only). 0x14 DBL_CNT (read-only). A write to either address clears both counters.
  - 0x18 STATUS: bit0 = busy (read-only).
  - Unmapped addresses read 0; writes to them are ignored.
- APB read: prdata is registered in the setup phase (psel & ~penable & ~pwrite) and held through the access phase. No wait states.
- Geometry for width N: K data bits, P Hamming bits.
  - N = 8: K = 4, P = 3. N = 16: K = 11, P = 4. N = 32: K = 26, P = 5.
  - Codeword bits [K-1:0] = data. Bits [K+P-1:K] = p0..p(P-1). Bit [N-1] = overall parity.
  - Data bit i occupies the i-th non-power-of-two position in 1..N-1 (3, 5, 6, 7, 9, ...).
  - pj = XOR of the data bits whose position has bit j set.
  - Overall parity = XOR of codeword bits [N-2:0] (even parity).
  - Encode ignores DATA_IN bits at K and above. Decode ignores input bits at N and above.
- Decode:
  - s = recomputed parity XOR received parity. o = XOR of all N received bits.
  - s = 0, o = 0: 0 errors.
  - o = 1: 1 error, corrected as follows. s = 0 means the overall bit; s = 2^j means pj; otherwise the data bit at position s.
  - o = 0, s != 0: 2 errors; data_out is the uncorrected data.
  - Decode and full-channel data_out = the K data bits, zero-extended.
  - Encode data_out = the N-bit codeword, zero-extended, with num_of_errors = 0.
- FSM: IDLE -> LOAD -> ENC and/or SYN -> FIX -> DONE -> IDLE.
  - Encode skips SYN and FIX. Decode skips ENC.
  - Full channel runs ENC, then SYN on (codeword XOR NOISE[N-1:0]), then FIX.
  - DATA_IN, NOISE and CODEWORD_WIDTH are snapshotted in LOAD.
- Latency, counted from the clock edge that samples the CTRL write to the edge where operation_done rises: encode 2, decode 3, full channel 4.
  - data_out and num_of_errors update on that same edge and hold until the next operation completes.
  - operation_done is high for exactly one cycle.
- busy = FSM not in IDLE. While busy, all APB writes are ignored (CTRL included). Reads are served normally.
- Counters: on DONE of a decode or full-channel operation, SGL_CNT increments if num_of_errors = 1 and DBL_CNT increments if num_of_errors = 2.
  - Both are AMBA_WORD wide and saturate at all-ones (no wrap).
  - If a clear-write and an increment fall in the same cycle, the clear wins. This cannot occur while busy, because the clear-write is then ignored.

Test Plan:
- Width code 0, DATA_IN 0x0B, CTRL = 0 -> 2 cycles later operation_done = 1, data_out = 0x0000001B, num_of_errors = 0; SGL_CNT and DBL_CNT unchanged.
- Width code 0, DATA_IN 0x1A, CTRL = 1 -> 3 cycles later data_out = 0x0000000B, num_of_errors = 1, SGL_CNT = 1.
- Width code 0, DATA_IN 0x18, CTRL = 1 -> data_out = 0x00000008, num_of_errors = 2, DBL_CNT = 1.
- Width code 0, DATA_IN 0x0B, NOISE 0x80, CTRL = 2 -> 4 cycles later data_out = 0x0B, num_of_errors = 1. Repeat with NOISE 0x00 -> num_of_errors = 0.
- Widths 16 and 32: encode random data, then decode every single-bit flip and a sample of double flips -> the original data is returned with errors = 1, or errors = 2; no flip yields errors = 0. Compare against the reference model.
- Robustness:
  - Write DATA_IN while busy -> ignored; result unchanged.
  - Assert rst mid full-channel -> no operation_done; all outputs and registers 0.
  - Force SGL_CNT to all-ones -> stays saturated.
  - Write 0x10 -> both counters 0.
